vend_payout_ctrl: RTL

- Output-side companion to vending_machine: consumes its vend pulse (b) and change code, and executes the physical payout.
- Drives the product motor, then releases change coins one at a time from a 5rs coin hopper via req/ack handshakes.
- Tracks hopper inventory and flags low-change, short-change and hardware-timeout conditions.
- Sits between vending_machine and the dispenser/hopper actuators.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_payout_ctrl_if.sv | 31 +++
 rtl/vend_payout_ctrl_timeout_cnt.sv | 27 ++
 rtl/vend_payout_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vend payout controller: change codes, payout states
// and the change-code to coin-count mapping.
package vend_pkg;

  localparam int unsigned NEED_W = 2;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOTOR,
    ST_COIN,
    ST_GAP,
    ST_FAULT
  } payout_state_e;

  // Number of 5rs coins owed for a change code; the reserved code pays nothing.
  function automatic logic [NEED_W-1:0] coins_for_code(input logic [1:0] code);
    case (code)
      COIN_5:  return NEED_W'(1);
      COIN_10: return NEED_W'(2);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_payout_ctrl_if.sv
// Request, actuator handshake and status signals of the payout controller.
interface vend_payout_ctrl_if #(
  parameter int unsigned COIN_W = 8
);
  logic              vend;
  logic [1:0]        change;
  logic              motor_req;
  logic              motor_done;
  logic              coin_req;
  logic              coin_ack;
  logic              refill;
  logic [COIN_W-1:0] refill_cnt;
  logic [COIN_W-1:0] coins_left;
  logic              busy;
  logic              low_change;
  logic              short_change;
  logic              drop;
  logic              fault;

  // Environment side: vending machine, motor and hopper.
  modport master (
    output vend, change, motor_done, coin_ack, refill, refill_cnt,
    input  motor_req, coin_req, coins_left, busy, low_change, short_change, drop, fault
  );

  // Controller side.
  modport slave (
    input  vend, change, motor_done, coin_ack, refill, refill_cnt,
    output motor_req, coin_req, coins_left, busy, low_change, short_change, drop, fault
  );
endinterface

// File: rtl/vend_payout_ctrl_timeout_cnt.sv
// Ack wait timer shared by the motor and coin handshakes; expired is high
// during the ACK_TIMEOUT-th cycle of an uninterrupted wait.
module payout_timeout_cnt #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // Saturates at the expiry value; the controller leaves the wait state then.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vend_payout_ctrl.sv
// Payout controller: runs the product motor, then releases owed 5rs coins
// one at a time from the hopper while tracking its inventory.
module vend_payout_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned COIN_W      = 8,
  parameter int unsigned INIT_COINS  = 20,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  vend_payout_ctrl_if.slave bus
);

  payout_state_e     state_q, state_d;
  logic [COIN_W-1:0] coins_q, coins_d;
  logic [NEED_W-1:0] needed_q, needed_d;
  logic [NEED_W-1:0] need_in;
  logic [NEED_W-1:0] grant_need;
  logic              request;
  logic              short_need;
  logic              waiting;
  logic              tmo_clear;
  logic              tmo_expired;
  logic              short_c;
  logic              drop_c;

  assign need_in    = coins_for_code(bus.change);
  assign request    = bus.vend || (need_in != '0);
  assign short_need = COIN_W'(need_in) > coins_q;
  assign grant_need = short_need ? '0 : need_in;
  assign waiting    = (state_q == ST_MOTOR) || (state_q == ST_COIN);
  // Restart the timer on every state entry and keep it idle outside waits.
  assign tmo_clear  = !waiting || (state_d != state_q);

  payout_timeout_cnt #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (waiting),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      coins_q  <= COIN_W'(INIT_COINS);
      needed_q <= '0;
    end else begin
      state_q  <= state_d;
      coins_q  <= coins_d;
      needed_q <= needed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    coins_d  = coins_q;
    needed_d = needed_q;
    short_c  = 1'b0;
    drop_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (request) begin
          // Unpayable change is dropped up front so inventory can never underflow.
          short_c  = short_need;
          needed_d = grant_need;
          if (bus.vend) begin
            state_d = ST_MOTOR;
          end else if (grant_need != '0) begin
            state_d = ST_COIN;
          end
        end else if (bus.refill) begin
          coins_d = bus.refill_cnt;
        end
      end
      ST_MOTOR: begin
        if (bus.motor_done) begin
          state_d = (needed_q != '0) ? ST_COIN : ST_IDLE;
        end else if (tmo_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_COIN: begin
        if (bus.coin_ack) begin
          coins_d  = coins_q - COIN_W'(1);
          needed_d = needed_q - NEED_W'(1);
          state_d  = (needed_q == NEED_W'(2)) ? ST_GAP : ST_IDLE;
        end else if (tmo_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_GAP:   state_d = ST_COIN;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && request) begin
      drop_c = 1'b1;
    end
  end

  assign bus.motor_req    = (state_q == ST_MOTOR);
  assign bus.coin_req     = (state_q == ST_COIN);
  assign bus.fault        = (state_q == ST_FAULT);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.coins_left   = coins_q;
  assign bus.low_change   = (coins_q < COIN_W'(2));
  assign bus.short_change = short_c;
  assign bus.drop         = drop_c;

endmodule
